i2c_arbiter: RTL and testbench



---
 rtl/i2c_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_i2c_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_arbiter : round-robin arbiter/sequencer sharing one single-byte I2C master
// Revision    : 1.0
// ----------------------------------------------------------------------------
module i2c_arbiter #(
   parameter int NREQ      = 4,
   parameter int LAUNCH_TO = 1023,
   parameter int BUSY_TO   = 16383
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_rw,
   input  logic [7*NREQ-1:0]    req_addr,
   input  logic [8*NREQ-1:0]    req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic [7:0]           rdata,
   output logic                 busy,
   output logic                 m_en,
   output logic                 m_rw,
   output logic [6:0]           m_addr,
   output logic [7:0]           m_data,
   input  logic                 m_ready,
   input  logic [7:0]           m_data_out
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [15:0]   c_LAUNCH_TO = 16'(LAUNCH_TO);
   localparam logic [15:0]   c_BUSY_TO   = 16'(BUSY_TO);
   localparam logic [IW-1:0] c_LAST_RST  = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_BUSY   = 2'd2
   } state_t;

   state_t            r_state, w_state_n;
   logic              r_sync1, r_rdy_s;
   logic [NREQ-1:0]   r_gnt, w_gnt_n;
   logic [NREQ-1:0]   r_done, w_done_n;
   logic              r_err, w_err_n;
   logic              r_m_en, w_m_en_n;
   logic              r_m_rw, w_m_rw_n;
   logic [6:0]        r_m_addr, w_m_addr_n;
   logic [7:0]        r_m_data, w_m_data_n;
   logic [7:0]        r_rdata, w_rdata_n;
   logic [IW-1:0]     r_last, w_last_n;
   logic [15:0]       r_timer, w_timer_n, w_timer_inc;

   logic              w_found;
   logic [IW-1:0]     w_win;
   logic [NREQ-1:0]   w_sel_oh;
   logic [6:0]        w_sel_addr;
   logic [7:0]        w_sel_data;
   logic              w_sel_rw;

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && req[(int'(r_last) + k) % NREQ]) begin
            w_found = 1'b1;
            w_win   = IW'((int'(r_last) + k) % NREQ);
         end
      end
   end

   always_comb begin
      w_sel_oh   = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_rw   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (IW'(i) == w_win) begin
            w_sel_oh[i] = 1'b1;
            w_sel_addr  = req_addr[7*i +: 7];
            w_sel_data  = req_wdata[8*i +: 8];
            w_sel_rw    = req_rw[i];
         end
      end
   end

   assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

   always_comb begin
      w_state_n  = r_state;
      w_gnt_n    = r_gnt;
      w_done_n   = '0;
      w_err_n    = 1'b0;
      w_m_en_n   = r_m_en;
      w_m_rw_n   = r_m_rw;
      w_m_addr_n = r_m_addr;
      w_m_data_n = r_m_data;
      w_rdata_n  = r_rdata;
      w_last_n   = r_last;
      w_timer_n  = r_timer;
      case (r_state)
         S_IDLE: begin
            if (w_found && r_rdy_s) begin
               w_gnt_n    = w_sel_oh;
               w_m_en_n   = 1'b1;
               w_m_rw_n   = w_sel_rw;
               w_m_addr_n = w_sel_addr;
               w_m_data_n = w_sel_data;
               w_last_n   = w_win;
               w_timer_n  = '0;
               w_state_n  = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // Dropping en as soon as the master leaves idle limits it to one byte.
            if (!r_rdy_s) begin
               w_m_en_n  = 1'b0;
               w_timer_n = '0;
               w_state_n = S_BUSY;
            end else if (r_timer == c_LAUNCH_TO) begin
               w_m_en_n  = 1'b0;
               w_gnt_n   = '0;
               w_err_n   = 1'b1;
               w_state_n = S_IDLE;
            end else begin
               w_timer_n = w_timer_inc;
            end
         end
         S_BUSY: begin
            if (r_rdy_s) begin
               if (r_m_rw) begin
                  w_rdata_n = m_data_out;
               end
               w_done_n  = r_gnt;
               w_gnt_n   = '0;
               w_state_n = S_IDLE;
            end else if (r_timer == c_BUSY_TO) begin
               w_gnt_n   = '0;
               w_err_n   = 1'b1;
               w_state_n = S_IDLE;
            end else begin
               w_timer_n = w_timer_inc;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sync1  <= 1'b0;
         r_rdy_s  <= 1'b0;
         r_gnt    <= '0;
         r_done   <= '0;
         r_err    <= 1'b0;
         r_m_en   <= 1'b0;
         r_m_rw   <= 1'b0;
         r_m_addr <= '0;
         r_m_data <= '0;
         r_rdata  <= '0;
         r_last   <= c_LAST_RST;
         r_timer  <= '0;
      end else begin
         r_state  <= w_state_n;
         r_sync1  <= m_ready;
         r_rdy_s  <= r_sync1;
         r_gnt    <= w_gnt_n;
         r_done   <= w_done_n;
         r_err    <= w_err_n;
         r_m_en   <= w_m_en_n;
         r_m_rw   <= w_m_rw_n;
         r_m_addr <= w_m_addr_n;
         r_m_data <= w_m_data_n;
         r_rdata  <= w_rdata_n;
         r_last   <= w_last_n;
         r_timer  <= w_timer_n;
      end
   end

   assign gnt    = r_gnt;
   assign done   = r_done;
   assign err    = r_err;
   assign rdata  = r_rdata;
   // Stays high through the done/err cycle, which is already back in IDLE.
   assign busy   = (r_state != S_IDLE) | (|r_done) | r_err;
   assign m_en   = r_m_en;
   assign m_rw   = r_m_rw;
   assign m_addr = r_m_addr;
   assign m_data = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_arbiter : directed self-checking bench for i2c_arbiter (NREQ=4)
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_i2c_arbiter;

   logic        clk, rst;
   logic [3:0]  req, req_rw, gnt, done;
   logic [27:0] req_addr;
   logic [31:0] req_wdata;
   logic        err, busy, m_en, m_rw, m_ready;
   logic [7:0]  rdata, m_data, m_data_out;
   logic [6:0]  m_addr;

   int n_cmp = 0;
   int n_err = 0;

   i2c_arbiter #(.NREQ(4), .LAUNCH_TO(1023), .BUSY_TO(16383)) dut (
      .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .busy(busy), .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_data(m_data),
      .m_ready(m_ready), .m_data_out(m_data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Event recorder, sampled on the falling edge.
   int         men_cnt = 0, done_cnt = 0, err_cnt = 0, ovl_cnt = 0, b2b_cnt = 0, done_bad = 0;
   int         gnt_log[$];
   logic [3:0] prev_gnt = '0, prev_done = '0;
   initial forever begin
      @(negedge clk);
      if (m_en) men_cnt++;
      if (done != 0) begin
         done_cnt++;
         if (done !== prev_gnt) done_bad++;
      end
      if (err) err_cnt++;
      if ($countones(gnt) > 1) ovl_cnt++;
      if (gnt != 0 && prev_gnt == 0) begin
         for (int i = 0; i < 4; i++) if (gnt[i]) gnt_log.push_back(i);
         if (prev_done != 0) b2b_cnt++;
      end
      prev_gnt  = gnt;
      prev_done = done;
   end

   // Master model: idle until en, drop ready after mdl_drop, raise after mdl_busy.
   logic       mdl_on = 1'b1, mdl_level = 1'b1;
   int         mdl_drop = 200, mdl_busy = 5000;
   logic [7:0] mdl_rd = 8'h00;
   initial begin
      int phase, cnt;
      phase = 0; cnt = 0;
      m_ready = 1'b1; m_data_out = 8'h00;
      forever begin
         @(negedge clk); #3;
         if (!mdl_on) begin
            m_ready = mdl_level; phase = 0;
         end else begin
            case (phase)
               0: begin
                  m_ready = 1'b1;
                  if (m_en) begin cnt = 0; phase = 1; end
               end
               1: begin
                  cnt++;
                  if (cnt == mdl_drop) begin m_ready = 1'b0; m_data_out = mdl_rd; cnt = 0; phase = 2; end
               end
               default: begin
                  cnt++;
                  if (cnt == mdl_busy) begin m_ready = 1'b1; phase = 0; end
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(negedge clk); #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
      tick(); tick();
      n_cmp++; if (gnt !== 4'b0 || done !== 4'b0) begin n_err++; $display("FAIL rst_gnt_done: gnt=%b done=%b want 0", gnt, done); end
      n_cmp++; if (err !== 1'b0 || busy !== 1'b0 || m_en !== 1'b0) begin n_err++; $display("FAIL rst_flags: err=%b busy=%b m_en=%b want 0", err, busy, m_en); end
      n_cmp++; if ({m_rw, m_addr, m_data, rdata} !== 24'h0) begin n_err++; $display("FAIL rst_data: rw=%b addr=%h data=%h rdata=%h want 0", m_rw, m_addr, m_data, rdata); end
      rst = 1'b0;
      repeat (4) tick();
      n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0) begin n_err++; $display("FAIL rst_idle: busy=%b gnt=%b want 0", busy, gnt); end
   endtask

   task automatic test_round_robin();
      int base, d0, b0, o0, n;
      bit ok;
      int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
      base = gnt_log.size(); d0 = done_cnt; b0 = b2b_cnt; o0 = ovl_cnt; ok = 1'b0; n = 0;
      mdl_drop = 5; mdl_busy = 20;
      for (int i = 0; i < 4; i++) begin
         req_addr[7*i +: 7] = 7'(8'h10 + i); req_wdata[8*i +: 8] = 8'(i);
      end
      req = 4'b1111;
      for (int t = 0; t < 3000; t++) begin
         tick();
         n = gnt_log.size() - base;
         if (n >= 8) begin req = '0; ok = 1'b1; break; end
         else if (n >= 6) req = 4'b1010;
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout: grants=%0d want 8", n); end
      for (int t = 0; t < 200; t++) begin tick(); if (busy == 1'b0) break; end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: busy=%b want 0", busy); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (gnt_log.size() <= base + i || gnt_log[base + i] != exp_seq[i]) begin
            n_err++;
            $display("FAIL rr_order[%0d]: got %0d want %0d", i, (gnt_log.size() > base + i) ? gnt_log[base + i] : -1, exp_seq[i]);
         end
      end
      n_cmp++; if (ovl_cnt - o0 != 0) begin n_err++; $display("FAIL rr_overlap: cycles=%0d want 0", ovl_cnt - o0); end
      n_cmp++; if (done_cnt - d0 != 8) begin n_err++; $display("FAIL rr_done_count: got %0d want 8", done_cnt - d0); end
      n_cmp++; if (b2b_cnt - b0 != 7) begin n_err++; $display("FAIL rr_back_to_back: got %0d want 7", b2b_cnt - b0); end
      n_cmp++; if (done_bad != 0) begin n_err++; $display("FAIL rr_done_target: bad=%0d want 0", done_bad); end
   endtask

   task automatic test_single_write();
      int m0, d0, e0;
      bit found;
      found = 1'b0;
      mdl_drop = 200; mdl_busy = 5000; mdl_rd = 8'hEE;
      req_addr[6:0] = 7'h50; req_wdata[7:0] = 8'hA5; req_rw[0] = 1'b0;
      m0 = men_cnt; d0 = done_cnt; e0 = err_cnt;
      req = 4'b0001;
      tick();
      n_cmp++; if (gnt !== 4'b0001 || m_en !== 1'b1) begin n_err++; $display("FAIL wr_grant: gnt=%b m_en=%b want 0001 1", gnt, m_en); end
      n_cmp++; if (m_addr !== 7'h50 || m_data !== 8'hA5 || m_rw !== 1'b0) begin n_err++; $display("FAIL wr_fields: addr=%h data=%h rw=%b want 50 a5 0", m_addr, m_data, m_rw); end
      req = '0;
      for (int t = 0; t < 6000; t++) begin tick(); if (done != 0) begin found = 1'b1; break; end end
      n_cmp++; if (!found) begin n_err++; $display("FAIL wr_done_timeout: done never seen"); end
      n_cmp++; if (done !== 4'b0001 || gnt !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL wr_done_cycle: done=%b gnt=%b busy=%b want 0001 0000 1", done, gnt, busy); end
      n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL wr_rdata: got %h want 00", rdata); end
      tick();
      n_cmp++; if (busy !== 1'b0 || done !== 4'b0) begin n_err++; $display("FAIL wr_after: busy=%b done=%b want 0", busy, done); end
      n_cmp++; if (men_cnt - m0 != 203) begin n_err++; $display("FAIL wr_en_width: got %0d want 203", men_cnt - m0); end
      n_cmp++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin n_err++; $display("FAIL wr_pulses: done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
   endtask

   task automatic test_read();
      bit found;
      found = 1'b0;
      mdl_drop = 10; mdl_busy = 50; mdl_rd = 8'h3C;
      req_addr[20:14] = 7'h1D; req_rw[2] = 1'b1;
      req = 4'b0100;
      tick();
      n_cmp++; if (gnt !== 4'b0100 || m_rw !== 1'b1 || m_addr !== 7'h1D) begin n_err++; $display("FAIL rd_grant: gnt=%b rw=%b addr=%h want 0100 1 1d", gnt, m_rw, m_addr); end
      req = '0;
      for (int t = 0; t < 500; t++) begin tick(); if (done != 0) begin found = 1'b1; break; end end
      n_cmp++; if (!found || done !== 4'b0100) begin n_err++; $display("FAIL rd_done: done=%b want 0100", done); end
      n_cmp++; if (rdata !== 8'h3C) begin n_err++; $display("FAIL rd_data: got %h want 3c", rdata); end
      tick();
      n_cmp++; if (rdata !== 8'h3C || done !== 4'b0) begin n_err++; $display("FAIL rd_hold: rdata=%h done=%b want 3c 0000", rdata, done); end
   endtask

   task automatic test_req_drop();
      int g0;
      g0 = gnt_log.size();
      mdl_on = 1'b0; mdl_level = 1'b0;
      repeat (3) tick();
      req = 4'b1000;
      repeat (5) tick();
      req = '0;
      tick();
      mdl_level = 1'b1;
      repeat (20) tick();
      n_cmp++; if (gnt_log.size() != g0) begin n_err++; $display("FAIL drop_no_grant: grants=%0d want 0", gnt_log.size() - g0); end
   endtask

   task automatic test_launch_timeout();
      int kk, e0;
      logic [3:0] g_at;
      logic en_at;
      kk = -1; g_at = 4'hF; en_at = 1'b1; e0 = err_cnt;
      req_addr[13:7] = 7'h22; req_rw[1] = 1'b0;
      req = 4'b0010;
      tick();
      n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL lto_grant: gnt=%b want 0010", gnt); end
      req = '0;
      for (int k = 1; k <= 1100; k++) begin
         tick();
         if (err) begin kk = k; g_at = gnt; en_at = m_en; break; end
      end
      n_cmp++; if (kk != 1024) begin n_err++; $display("FAIL lto_cycle: err at %0d want 1024", kk); end
      n_cmp++; if (g_at !== 4'b0 || en_at !== 1'b0) begin n_err++; $display("FAIL lto_outputs: gnt=%b m_en=%b want 0", g_at, en_at); end
      tick();
      n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL lto_idle: busy=%b err=%b want 0", busy, err); end
      n_cmp++; if (err_cnt - e0 != 1) begin n_err++; $display("FAIL lto_err_count: got %0d want 1", err_cnt - e0); end
   endtask

   task automatic test_busy_timeout();
      int kk, jj, d0, bad;
      logic [3:0] g;
      kk = -1; jj = -1; bad = 0; g = '0; d0 = done_cnt;
      req_addr[20:14] = 7'h2A; req_wdata[23:16] = 8'h77; req_rw[2] = 1'b1;
      req = 4'b0100;
      tick();
      n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL bto_grant: gnt=%b want 0100", gnt); end
      mdl_level = 1'b0;
      for (int k = 1; k <= 17000; k++) begin tick(); if (err) begin kk = k; break; end end
      n_cmp++; if (kk != 16387) begin n_err++; $display("FAIL bto_cycle: err at %0d want 16387", kk); end
      n_cmp++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL bto_no_done: got %0d want 0", done_cnt - d0); end
      repeat (50) begin tick(); if (gnt != 0) bad++; end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bto_no_regrant: cycles=%0d want 0", bad); end
      mdl_level = 1'b1;
      for (int j = 1; j <= 20; j++) begin tick(); if (gnt != 0) begin jj = j; g = gnt; break; end end
      n_cmp++; if (jj != 3 || g !== 4'b0100) begin n_err++; $display("FAIL bto_regrant: at %0d gnt=%b want 3 0100", jj, g); end
   endtask

   task automatic test_reset_mid_busy();
      logic [3:0] g;
      g = '0;
      req = '0; mdl_level = 1'b0;
      repeat (10) tick();
      n_cmp++; if (busy !== 1'b1 || gnt !== 4'b0100 || m_en !== 1'b0) begin n_err++; $display("FAIL rmb_pre: busy=%b gnt=%b m_en=%b want 1 0100 0", busy, gnt, m_en); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmb_ctrl: gnt=%b done=%b err=%b busy=%b want 0", gnt, done, err, busy); end
      n_cmp++; if (m_en !== 1'b0 || {m_rw, m_addr, m_data} !== 16'h0 || rdata !== 8'h00) begin n_err++; $display("FAIL rmb_data: en=%b rw=%b addr=%h data=%h rdata=%h want 0", m_en, m_rw, m_addr, m_data, rdata); end
      tick();
      rst = 1'b0; mdl_on = 1'b1; mdl_drop = 10; mdl_busy = 50;
      req_addr[6:0] = 7'h11; req_addr[13:7] = 7'h12; req_rw[1:0] = 2'b00;
      req = 4'b0011;
      for (int t = 0; t < 50; t++) begin tick(); if (gnt != 0) begin g = gnt; break; end end
      n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL rmb_first_grant: gnt=%b want 0001", g); end
      req = '0;
      for (int t = 0; t < 1000; t++) begin tick(); if (busy == 1'b0) break; end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmb_complete: busy=%b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_write();
      test_read();
      test_req_drop();
      test_launch_timeout();
      test_busy_timeout();
      test_reset_mid_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
